// File: rtl/in_service_register.sv
// 8259A In-Service Register stage: captures acknowledged levels on the first
// INTA, clears them on EOI or on the second INTA in AEOI mode, and maintains
// the rotating lowest-priority pointer used by the priority resolver.
// Optional: define ISR_EOI_ERROR_EN to add the eoi_error output.

// One in-service bit; a set in the same cycle as a clear wins.
module isr_cell (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  output logic q
);
  // Bit state: set has precedence over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end
endmodule

module in_service_register #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inta_1,
  input  logic              inta_2,
  input  logic [NUM_IR-1:0] ack_vector,
  input  logic              aeoi_mode,
  input  logic              ocw2_valid,
  input  logic [2:0]        ocw2_cmd,
  input  logic [2:0]        ocw2_level,
  output logic [NUM_IR-1:0] isr,
  output logic [2:0]        lowest_priority,
  output logic              rotate_aeoi,
`ifdef ISR_EOI_ERROR_EN
  output logic              eoi_error,
`endif
  output logic              in_service
);
  localparam logic [2:0] CMD_CLR_ROT = 3'b000;
  localparam logic [2:0] CMD_NS_EOI  = 3'b001;
  localparam logic [2:0] CMD_SP_EOI  = 3'b011;
  localparam logic [2:0] CMD_SET_ROT = 3'b100;
  localparam logic [2:0] CMD_ROT_NS  = 3'b101;
  localparam logic [2:0] CMD_SET_PRI = 3'b110;
  localparam logic [2:0] CMD_ROT_SP  = 3'b111;

  logic [2:0]        cur_level;
  logic [2:0]        ack_idx;
  logic              ack_any;
  logic              ns_found;
  logic [2:0]        ns_level;
  logic [NUM_IR-1:0] set_vec;
  logic [NUM_IR-1:0] clr_vec;
  logic [2:0]        lp_nxt;
  logic              rot_nxt;
  logic              err_nxt;

  assign ack_any    = |ack_vector;
  assign in_service = |isr;

  // Encode the one-hot acknowledge vector into a level index.
  always_comb begin
    ack_idx = '0;
    for (int i = 0; i < NUM_IR; i++)
      if (ack_vector[i]) ack_idx = 3'(i);
  end

  // Highest-priority in-service level: scan from lowest_priority+1 with wrap.
  always_comb begin
    logic [2:0] idx;
    ns_found = 1'b0;
    ns_level = '0;
    for (int k = 1; k <= NUM_IR; k++) begin
      idx = lowest_priority + 3'(k);
      if (!ns_found && isr[idx]) begin
        ns_found = 1'b1;
        ns_level = idx;
      end
    end
  end

  // Clear/set vectors and pointer/flag next state; OCW2 overrides AEOI rotation.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    lp_nxt  = lowest_priority;
    rot_nxt = rotate_aeoi;
    err_nxt = 1'b0;
    if (inta_1 && ack_any) set_vec = ack_vector;
    if (inta_2 && aeoi_mode) begin
      clr_vec[cur_level] = 1'b1;
      if (rotate_aeoi) lp_nxt = cur_level;
    end
    if (ocw2_valid) begin
      unique case (ocw2_cmd)
        CMD_NS_EOI, CMD_ROT_NS: begin
          if (ns_found) begin
            clr_vec[ns_level] = 1'b1;
            if (ocw2_cmd == CMD_ROT_NS) lp_nxt = ns_level;
          end
          err_nxt = !ns_found;
        end
        CMD_SP_EOI, CMD_ROT_SP: begin
          clr_vec[ocw2_level] = 1'b1;
          if (ocw2_cmd == CMD_ROT_SP) lp_nxt = ocw2_level;
          err_nxt = !isr[ocw2_level];
        end
        CMD_SET_PRI: lp_nxt  = ocw2_level;
        CMD_SET_ROT: rot_nxt = 1'b1;
        CMD_CLR_ROT: rot_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  // One storage cell per interrupt level.
  for (genvar g = 0; g < NUM_IR; g++) begin : g_cell
    isr_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .set  (set_vec[g]),
      .clr  (clr_vec[g]),
      .q    (isr[g])
    );
  end

  // Level being serviced; only a real (non-spurious) acknowledge reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cur_level <= '0;
    else if (inta_1 && ack_any) cur_level <= ack_idx;
  end

  // Priority pointer and rotate-in-AEOI flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lowest_priority <= 3'd7;
      rotate_aeoi     <= 1'b0;
    end else begin
      lowest_priority <= lp_nxt;
      rotate_aeoi     <= rot_nxt;
    end
  end

`ifdef ISR_EOI_ERROR_EN
  // One-cycle pulse after an EOI that found nothing to clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) eoi_error <= 1'b0;
    else       eoi_error <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_in_service_register.sv
module tb_in_service_register;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inta_1 = 0, inta_2 = 0, aeoi_mode = 0, ocw2_valid = 0;
  logic [7:0] ack_vector = '0;
  logic [2:0] ocw2_cmd = '0, ocw2_level = '0;
  logic [7:0] isr;
  logic [2:0] lowest_priority;
  logic       rotate_aeoi, in_service;
  logic       eoi_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit m_isr [8];
  int m_lp, m_cur;
  bit m_rot, m_err;

  in_service_register dut (
    .clk(clk), .reset(reset), .inta_1(inta_1), .inta_2(inta_2),
    .ack_vector(ack_vector), .aeoi_mode(aeoi_mode), .ocw2_valid(ocw2_valid),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level), .isr(isr),
    .lowest_priority(lowest_priority), .rotate_aeoi(rotate_aeoi),
`ifdef ISR_EOI_ERROR_EN
    .eoi_error(eoi_error),
`endif
    .in_service(in_service)
  );

`ifndef ISR_EOI_ERROR_EN
  assign eoi_error = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [7:0] m_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_isr[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_isr[i] = 0;
    m_lp = 7; m_cur = 0; m_rot = 0; m_err = 0;
  endtask

  // Apply the rules of one clock to the reference state, from the inputs.
  task automatic m_clock();
    bit pre [8];
    bit clr [8];
    int new_lp, found;
    bit err;
    pre = m_isr;
    for (int i = 0; i < 8; i++) clr[i] = 0;
    new_lp = m_lp; err = 0;
    if (inta_2 && aeoi_mode) begin
      clr[m_cur] = 1;
      if (m_rot) new_lp = m_cur;
    end
    if (ocw2_valid) begin
      case (ocw2_cmd)
        3'b001, 3'b101: begin
          found = -1;
          for (int p = 0; p < 8; p++)
            if (found < 0 && pre[(m_lp + 1 + p) % 8]) found = (m_lp + 1 + p) % 8;
          if (found >= 0) begin
            clr[found] = 1;
            if (ocw2_cmd == 3'b101) new_lp = found;
          end else err = 1;
        end
        3'b011, 3'b111: begin
          if (!pre[ocw2_level]) err = 1;
          clr[ocw2_level] = 1;
          if (ocw2_cmd == 3'b111) new_lp = int'(ocw2_level);
        end
        3'b110: new_lp = int'(ocw2_level);
        3'b100: m_rot = 1;
        3'b000: m_rot = 0;
        default: ;
      endcase
    end
    for (int i = 0; i < 8; i++) m_isr[i] = pre[i] & ~clr[i];
    if (inta_1 && ack_vector != 0)
      for (int i = 0; i < 8; i++)
        if (ack_vector[i]) begin m_isr[i] = 1; m_cur = i; end
    m_lp = new_lp;
    m_err = err;
  endtask

  // Advance one clock, update the model, then drop the single-cycle strobes.
  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
    inta_1 = 0; inta_2 = 0; ocw2_valid = 0; ack_vector = '0;
  endtask

  task automatic do_inta1(input logic [7:0] v);
    inta_1 = 1; ack_vector = v; tick();
  endtask

  task automatic do_ocw2(input logic [2:0] c, input logic [2:0] l);
    ocw2_valid = 1; ocw2_cmd = c; ocw2_level = l; tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; m_reset();
    #2;
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 4;
    if (isr !== 8'h00) begin n_fail++; $display("FAIL reset_isr got %h exp 00", isr); end
    if (lowest_priority !== 3'd7) begin n_fail++; $display("FAIL reset_lp got %0d exp 7", lowest_priority); end
    if (rotate_aeoi !== 1'b0) begin n_fail++; $display("FAIL reset_rot got %b exp 0", rotate_aeoi); end
    if (in_service !== 1'b0) begin n_fail++; $display("FAIL reset_insvc got %b exp 0", in_service); end
  endtask

  task automatic test_inta1();
    do_inta1(8'h10);
    n_checks += 3;
    if (isr !== 8'h10) begin n_fail++; $display("FAIL inta1_isr got %h exp 10", isr); end
    if (in_service !== 1'b1) begin n_fail++; $display("FAIL inta1_insvc got %b exp 1", in_service); end
    if (lowest_priority !== 3'd7) begin n_fail++; $display("FAIL inta1_lp got %0d exp 7", lowest_priority); end
    do_inta1(8'h00);
    n_checks++;
    if (isr !== 8'h10) begin n_fail++; $display("FAIL spurious_isr got %h exp 10", isr); end
  endtask

  task automatic test_ns_eoi();
    do_inta1(8'h04);
    do_ocw2(3'b001, 3'd0);
    n_checks++;
    if (isr !== 8'h10) begin n_fail++; $display("FAIL nseoi_isr got %h exp 10", isr); end
  endtask

  task automatic test_set_priority();
    do_reset();
    do_inta1(8'h04); do_inta1(8'h10);
    do_ocw2(3'b110, 3'd2);
    n_checks++;
    if (lowest_priority !== 3'd2) begin n_fail++; $display("FAIL setpri_lp got %0d exp 2", lowest_priority); end
    do_ocw2(3'b001, 3'd0);
    n_checks += 2;
    if (isr !== 8'h04) begin n_fail++; $display("FAIL setpri_isr got %h exp 04", isr); end
    if (lowest_priority !== 3'd2) begin n_fail++; $display("FAIL setpri_lp2 got %0d exp 2", lowest_priority); end
  endtask

  task automatic test_rotate_ns();
    do_reset();
    do_inta1(8'h80); do_inta1(8'h01);
    do_ocw2(3'b110, 3'd0);
    do_ocw2(3'b101, 3'd0);
    n_checks += 2;
    if (isr !== 8'h01) begin n_fail++; $display("FAIL rotns_isr got %h exp 01", isr); end
    if (lowest_priority !== 3'd7) begin n_fail++; $display("FAIL rotns_lp got %0d exp 7", lowest_priority); end
    do_ocw2(3'b111, 3'd5);
    n_checks += 2;
    if (isr !== 8'h01) begin n_fail++; $display("FAIL rotsp_clear_isr got %h exp 01", isr); end
    if (lowest_priority !== 3'd5) begin n_fail++; $display("FAIL rotsp_clear_lp got %0d exp 5", lowest_priority); end
  endtask

  task automatic test_aeoi();
    do_reset();
    aeoi_mode = 1;
    do_ocw2(3'b100, 3'd0);
    do_inta1(8'h08);
    n_checks++;
    if (isr !== 8'h08) begin n_fail++; $display("FAIL aeoi_set_isr got %h exp 08", isr); end
    inta_2 = 1; tick();
    n_checks += 3;
    if (isr !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr got %h exp 00", isr); end
    if (lowest_priority !== 3'd3) begin n_fail++; $display("FAIL aeoi_lp got %0d exp 3", lowest_priority); end
    if (rotate_aeoi !== 1'b1) begin n_fail++; $display("FAIL aeoi_rot got %b exp 1", rotate_aeoi); end
    aeoi_mode = 0;
    do_inta1(8'h40);
    inta_2 = 1; tick();
    n_checks++;
    if (isr !== 8'h40) begin n_fail++; $display("FAIL noaeoi_isr got %h exp 40", isr); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    do_inta1(8'h08);
    inta_1 = 1; ack_vector = 8'h08;
    ocw2_valid = 1; ocw2_cmd = 3'b011; ocw2_level = 3'd3;
    tick();
    n_checks++;
    if (isr !== 8'h08) begin n_fail++; $display("FAIL same_isr got %h exp 08", isr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    aeoi_mode = 1;
    do_inta1(8'h21);
    @(negedge clk);
    reset = 1; m_reset();
    #1;
    n_checks++;
    if (isr !== 8'h00) begin n_fail++; $display("FAIL async_isr got %h exp 00", isr); end
    reset = 0;
    do_inta1(8'h00);
    inta_2 = 1; tick();
    n_checks++;
    if (isr !== 8'h00) begin n_fail++; $display("FAIL midrst_isr got %h exp 00", isr); end
    aeoi_mode = 0;
  endtask

`ifdef ISR_EOI_ERROR_EN
  task automatic test_eoi_error();
    do_reset();
    do_ocw2(3'b001, 3'd0);
    n_checks++;
    if (eoi_error !== 1'b1) begin n_fail++; $display("FAIL eoierr_pulse got %b exp 1", eoi_error); end
    tick();
    n_checks++;
    if (eoi_error !== 1'b0) begin n_fail++; $display("FAIL eoierr_drop got %b exp 0", eoi_error); end
  endtask
`endif

  task automatic test_random();
    logic [2:0] cmds [6];
    cmds = '{3'b001, 3'b011, 3'b101, 3'b111, 3'b110, 3'b100};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) aeoi_mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin inta_1 = 1; ack_vector = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7)); end
        1: inta_2 = 1;
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        ocw2_valid = 1;
        ocw2_cmd   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : cmds[$urandom_range(0, 5)];
        ocw2_level = 3'($urandom_range(0, 7));
      end
      tick();
      n_checks += 4;
      if (isr !== m_vec()) begin n_fail++; $display("FAIL rnd_isr[%0d] got %h exp %h", n, isr, m_vec()); end
      if (lowest_priority !== 3'(m_lp)) begin n_fail++; $display("FAIL rnd_lp[%0d] got %0d exp %0d", n, lowest_priority, m_lp); end
      if (rotate_aeoi !== m_rot) begin n_fail++; $display("FAIL rnd_rot[%0d] got %b exp %b", n, rotate_aeoi, m_rot); end
      if (in_service !== (m_vec() != 0)) begin n_fail++; $display("FAIL rnd_insvc[%0d] got %b exp %b", n, in_service, m_vec() != 0); end
`ifdef ISR_EOI_ERROR_EN
      n_checks++;
      if (eoi_error !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b exp %b", n, eoi_error, m_err); end
`endif
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_inta1();
    test_ns_eoi();
    test_set_priority();
    test_rotate_ns();
    test_aeoi();
    test_same_cycle();
    test_reset_mid();
`ifdef ISR_EOI_ERROR_EN
    test_eoi_error();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/in_service_register.md
Name: in_service_register

Overview:
- Clocked In-Service Register (ISR) stage directly downstream of the priority resolver in the 8259A PIC.
- Captures the one-hot vector of the request being acknowledged on the first INTA and holds it as in-service.
- Clears bits on EOI commands (OCW2) or automatically on the second INTA in AEOI mode.
- Maintains the rotating lowest-priority pointer that the resolver uses to rotate priorities.

Parameters:
- NUM_IR, 8, number of interrupt levels; fixed at 8 for 8259A compatibility; pointer width is 3.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- inta_1  input  1  single-cycle strobe, first INTA pulse
- inta_2  input  1  single-cycle strobe, second INTA pulse
- ack_vector  input  8  one-hot vector of the winning request from the resolver; sampled on inta_1
- aeoi_mode  input  1  ICW4 AEOI bit, static configuration level
- ocw2_valid  input  1  single-cycle strobe, OCW2 written
- ocw2_cmd  input  3  OCW2 R/SL/EOI bits
- ocw2_level  input  3  OCW2 L2..L0
- isr  output  8  in-service bits
- lowest_priority  output  3  current lowest-priority level; highest priority is (lowest_priority+1) mod 8
- rotate_aeoi  output  1  rotate-in-AEOI flag
- in_service  output  1  OR of isr

Behaviour:
- Reset values: isr=0, lowest_priority=7, rotate_aeoi=0, in_service=0, internal cur_level=0.
- All outputs are registered and change one clock after the qualifying strobe. in_service is combinational from isr.
- inta_1:
  - isr |= ack_vector.
  - cur_level is loaded with the encoded index of ack_vector.
  - If ack_vector is 0, nothing changes; this is the spurious case.
- inta_2 with aeoi_mode=1:
  - Clear isr[cur_level].
  - If rotate_aeoi=1, also set lowest_priority=cur_level.
- inta_2 with aeoi_mode=0: ignored.
- ocw2_cmd decode on ocw2_valid:
  - 001 non-specific EOI: clear the highest-priority set isr bit. The search starts at (lowest_priority+1) mod 8 and wraps through 7→0.
  - 011 specific EOI: clear isr[ocw2_level].
  - 101 rotate on non-specific EOI: same clear as 001, then lowest_priority = the cleared level.
  - 111 rotate on specific EOI: clear isr[ocw2_level], lowest_priority=ocw2_level.
  - 110 set priority: lowest_priority=ocw2_level; isr unchanged.
  - 100 set rotate_aeoi=1; 000 clear rotate_aeoi=0; 010 no-op.
- A non-specific EOI (001 or 101) with isr=0 does nothing; lowest_priority is not changed.
- A specific EOI on an already-clear bit leaves isr unchanged. For 111, the pointer still updates.
- Same-cycle events:
  - Clears from EOI and from the AEOI inta_2 are evaluated against the pre-cycle isr.
  - The inta_1 set is applied after clears. If set and clear target the same bit, set wins.
  - If both EOI and AEOI update lowest_priority in the same cycle, the OCW2 command wins.
  - inta_1 and inta_2 in the same cycle is illegal and not checked.
- Reset asserted mid-sequence, for example between inta_1 and inta_2, discards cur_level. A following inta_2 clears bit 0, which is already 0.

Optional Feature:
- Macro: ISR_EOI_ERROR_EN.
- When defined, an extra output port eoi_error (1 bit, registered, reset 0) is added.
- eoi_error pulses high for one cycle after any of these:
  - a non-specific EOI (001 or 101) issued while isr=0;
  - a specific EOI (011 or 111) issued while isr[ocw2_level]=0.
- When not defined, the port is absent and no error logic is built. All other behaviour is identical.

Test Plan:
- Reset, then inta_1 with ack_vector=8'h10 → after one clk: isr=8'h10, in_service=1, lowest_priority=7.
- isr=8'h14, lowest_priority=7, ocw2_cmd=001 → isr=8'h10 (level 2 is highest priority).
- isr=8'h14, ocw2_cmd=110 with level=2, then ocw2_cmd=001 → isr=8'h04 (level 4 is highest after 3); lowest_priority=2.
- isr=8'h81, ocw2_cmd=101 with lowest_priority=0 → level 7 cleared (search 1..7), isr=8'h01, lowest_priority=7.
- aeoi_mode=1, ocw2_cmd=100, inta_1 with ack_vector=8'h08, then inta_2 → isr=0, lowest_priority=3, rotate_aeoi=1.
- Same-cycle: isr=8'h08, inta_1 with ack_vector=8'h08 and ocw2_cmd=011 level=3 → isr=8'h08. Async reset mid-clock → isr=0 immediately. With ISR_EOI_ERROR_EN: ocw2_cmd=001 on isr=0 → eoi_error=1 for exactly one cycle.
